// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// result packed as {remainder, quotient} for the HI/LO write path.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   // state  | meaning
   // FREE   | idle, outputs zero, waiting for start_i
   // BYZERO | divisor was zero, next edge posts a zero result
   // ON     | iterating, one quotient bit per edge
   // END    | result valid, held until start_i drops
   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   part_q, part_d;
   logic               sgn1_q, sgn1_d;
   logic               sgn2_q, sgn2_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;

   logic               accept;
   logic               abort;
   logic               last;
   logic               neg1, neg2;
   logic [WIDTH:0]     trial;
   logic [WIDTH:0]     diff;
   logic               qbit;
   logic [WIDTH-1:0]   rem_step;
   logic [WIDTH-1:0]   quo_step;
   logic [WIDTH-1:0]   rem_fin;
   logic [WIDTH-1:0]   quo_fin;

   assign accept = start_i & ~annul_i;
   assign abort  = annul_i | ~start_i;
   assign last   = (cnt_q == CNT_LAST);
   assign neg1   = signed_div_i & opdata1_i[WIDTH-1];
   assign neg2   = signed_div_i & opdata2_i[WIDTH-1];

   // Trial is one bit wider than the divisor so divisors with the MSB set
   // still compare correctly; the borrow bit of the subtraction is the
   // inverted quotient bit.
   assign trial    = {part_q, dvd_q[WIDTH-1]};
   assign diff     = trial - {1'b0, dvs_q};
   assign qbit     = ~diff[WIDTH];
   assign rem_step = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_step = {dvd_q[WIDTH-2:0], qbit};
   assign quo_fin  = (sgn1_q ^ sgn2_q) ? -quo_step : quo_step;
   assign rem_fin  = sgn1_q ? -rem_step : rem_step;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_FREE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         part_q   <= '0;
         sgn1_q   <= 1'b0;
         sgn2_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         part_q   <= part_d;
         sgn1_q   <= sgn1_d;
         sgn2_q   <= sgn2_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FREE: begin
            if (accept) state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
         end
         S_BYZERO: state_d = S_END;
         S_ON: begin
            if (abort)     state_d = S_FREE;
            else if (last) state_d = S_END;
         end
         S_END: begin
            if (!start_i) state_d = S_FREE;
         end
         default: state_d = S_FREE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      part_d   = part_q;
      sgn1_d   = sgn1_q;
      sgn2_d   = sgn2_q;
      result_d = result_q;
      ready_d  = ready_q;
      unique case (state_q)
         S_FREE: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (accept) begin
               dvd_d  = neg1 ? -opdata1_i : opdata1_i;
               dvs_d  = neg2 ? -opdata2_i : opdata2_i;
               sgn1_d = neg1;
               sgn2_d = neg2;
               cnt_d  = '0;
               part_d = '0;
            end
         end
         S_BYZERO: begin
            result_d = '0;
            ready_d  = 1'b1;
         end
         S_ON: begin
            if (abort) begin
               result_d = '0;
               ready_d  = 1'b0;
            end else begin
               part_d = rem_step;
               dvd_d  = quo_step;
               cnt_d  = cnt_q + CW'(1);
               if (last) begin
                  result_d = {rem_fin, quo_fin};
                  ready_d  = 1'b1;
               end
            end
         end
         S_END: begin
            if (!start_i) begin
               result_d = '0;
               ready_d  = 1'b0;
            end
         end
         default: begin
            result_d = '0;
            ready_d  = 1'b0;
         end
      endcase
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned values, divide by
// zero, abort paths and synchronous reset in the middle of a divide.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks   = 0;
   int failures = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      annul_i      = 1'b0;
      start_i      = 1'b1;
   endtask

   // Advances until ready_o rises or the budget runs out; returns edge count.
   task automatic wait_ready(input int max_edges, output int edges);
      bit done;
      edges = 0;
      done  = 0;
      while (!done && edges < max_edges) begin
         tick();
         edges++;
         if (ready_o === 1'b1) done = 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = 32'd10; opdata2_i = 32'd2;
      tick(); tick(); tick();
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("FAIL reset_state ready=%b result=%h required ready=0 result=0", ready_o, result_o);
      end
      start_i = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_unsigned_latency();
      bit early;
      early = 0;
      issue(1'b0, 32'd100, 32'd7);
      tick();
      opdata1_i = 32'hDEAD_BEEF;
      opdata2_i = 32'd3;
      signed_div_i = 1'b1;
      if (ready_o !== 1'b0) early = 1;
      for (int e = 2; e <= 32; e++) begin
         tick();
         if (ready_o !== 1'b0) early = 1;
      end
      checks++;
      if (early) begin
         failures++;
         $display("FAIL udiv_early_ready ready rose before edge 33, required low through edge 32");
      end
      tick();
      checks++;
      if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
         failures++;
         $display("FAIL udiv_100_7 ready=%b result=%h required ready=1 result=%h",
                  ready_o, result_o, 64'h00000002_0000000E);
      end
      start_i = 1'b0;
      tick();
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("FAIL udiv_release ready=%b result=%h required ready=0 result=0", ready_o, result_o);
      end
   endtask

   task automatic test_values();
      int n;
      logic        s_t [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] a_t [5] = '{32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 32'd7, 32'hFFFFFFFF};
      logic [31:0] b_t [5] = '{32'd2, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000001};
      logic [63:0] r_t [5] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000000_FFFFFFFF,
                               64'h00000000_80000000, 64'h00000001_FFFFFFFD,
                               64'h7FFFFFFE_00000001};
      for (int i = 0; i < 5; i++) begin
         issue(s_t[i], a_t[i], b_t[i]);
         wait_ready(40, n);
         checks++;
         if (n !== 33 || result_o !== r_t[i]) begin
            failures++;
            $display("FAIL value_%0d edges=%0d result=%h required edges=33 result=%h",
                     i, n, result_o, r_t[i]);
         end
         start_i = 1'b0;
         tick();
      end
   endtask

   task automatic test_div_by_zero();
      bit held;
      issue(1'b1, 32'd5, 32'd0);
      tick();
      checks++;
      if (ready_o !== 1'b0) begin
         failures++;
         $display("FAIL divzero_edge1 ready=%b required 0", ready_o);
      end
      tick();
      checks++;
      if (ready_o !== 1'b1 || result_o !== 64'd0) begin
         failures++;
         $display("FAIL divzero_edge2 ready=%b result=%h required ready=1 result=0", ready_o, result_o);
      end
      held = 1;
      for (int i = 0; i < 5; i++) begin
         annul_i = (i == 2);
         tick();
         if (ready_o !== 1'b1 || result_o !== 64'd0) held = 0;
      end
      annul_i = 1'b0;
      checks++;
      if (!held) begin
         failures++;
         $display("FAIL divzero_hold ready=%b result=%h required ready=1 result=0 for 5 edges",
                  ready_o, result_o);
      end
      start_i = 1'b0;
      tick();
      checks++;
      if (ready_o !== 1'b0) begin
         failures++;
         $display("FAIL divzero_release ready=%b required 0", ready_o);
      end
   endtask

   // use_annul selects annul_i vs. dropping start_i as the abort mechanism.
   task automatic test_abort(input bit use_annul);
      bit rose;
      int n;
      rose = 0;
      issue(1'b0, 32'd1000, 32'd3);
      for (int e = 1; e <= 9; e++) begin
         tick();
         if (ready_o !== 1'b0) rose = 1;
      end
      opdata1_i = 32'd9;
      opdata2_i = 32'd3;
      if (use_annul) annul_i = 1'b1;
      else           start_i = 1'b0;
      tick();
      checks++;
      if (rose || ready_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("FAIL abort_%0d ready=%b result=%h required ready=0 result=0 throughout",
                  use_annul, ready_o, result_o);
      end
      annul_i = 1'b0;
      start_i = 1'b1;
      wait_ready(40, n);
      checks++;
      if (n !== 33 || result_o !== 64'h00000000_00000003) begin
         failures++;
         $display("FAIL abort_restart_%0d edges=%0d result=%h required edges=33 result=%h",
                  use_annul, n, result_o, 64'h00000000_00000003);
      end
      start_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_op();
      int n;
      issue(1'b0, 32'd1000, 32'd7);
      for (int e = 1; e <= 19; e++) tick();
      rst = 1'b0;
      tick();
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         failures++;
         $display("FAIL reset_mid_op ready=%b result=%h required ready=0 result=0", ready_o, result_o);
      end
      rst = 1'b1;
      wait_ready(40, n);
      checks++;
      if (n !== 33 || result_o !== 64'h00000006_0000008E) begin
         failures++;
         $display("FAIL reset_restart edges=%0d result=%h required edges=33 result=%h",
                  n, result_o, 64'h00000006_0000008E);
      end
      start_i = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_unsigned_latency();
      test_values();
      test_div_by_zero();
      test_abort(1'b1);
      test_abort(1'b0);
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
